// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed N-digit 7-segment scan controller with frame-synchronous double-buffered digits
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          lzb,
  input  logic                          wr_en,
  input  logic [$clog2(NUM_DIGITS)-1:0] wr_addr,
  input  logic [3:0]                    wr_data,
  input  logic                          commit_req,
  output logic                          commit_done,
  output logic                          frame_tick,
  output logic [3:0]                    bcd_out,
  output logic [NUM_DIGITS-1:0]         digit_en
);
  localparam int AW     = $clog2(NUM_DIGITS);
  localparam int CW     = $clog2(REFRESH_DIV + 1);
  localparam int ON_CYC = REFRESH_DIV - BLANK_CYCLES;
  typedef enum logic [1:0] {S_OFF, S_SCAN, S_GUARD} state_t;
  state_t                       r_state, w_state;
  logic [AW-1:0]                r_idx, w_idx;
  logic [CW-1:0]                r_cnt, w_cnt;
  logic [NUM_DIGITS-1:0][3:0]   r_active, r_shadow, w_active;
  logic [NUM_DIGITS-1:0]        r_digit_en, w_blank;
  logic [3:0]                   r_bcd, w_bcd;
  logic                         r_pending, r_commit_done, r_frame_tick;
  logic                         w_frame_end, w_apply, w_run;
  // next scan position: ON slot, then guard gap, wrapping to digit 0 at frame end
  always_comb begin
    w_state     = r_state;
    w_idx       = r_idx;
    w_cnt       = r_cnt + 1'b1;
    w_frame_end = 1'b0;
    if (!en) begin
      w_state = S_OFF;
      w_idx   = '0;
      w_cnt   = '0;
    end else begin
      case (r_state)
        S_OFF: begin
          w_state = S_SCAN;
          w_idx   = '0;
          w_cnt   = '0;
        end
        S_SCAN: if (r_cnt == CW'(ON_CYC - 1)) begin
          w_state = S_GUARD;
          w_cnt   = '0;
        end
        S_GUARD: if (r_cnt == CW'(BLANK_CYCLES - 1)) begin
          w_state     = S_SCAN;
          w_cnt       = '0;
          w_frame_end = r_idx == AW'(NUM_DIGITS - 1);
          w_idx       = w_frame_end ? '0 : r_idx + 1'b1;
        end
        default: begin
          w_state = S_OFF;
          w_idx   = '0;
          w_cnt   = '0;
        end
      endcase
    end
  end
  // commit decision, leading-zero mask and the value the next slot will show
  always_comb begin
    w_apply  = r_pending && (w_frame_end || r_state == S_OFF);
    w_active = w_apply ? r_shadow : r_active;
    w_run    = 1'b1;
    w_blank  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_run      = w_run && (w_active[i] == 4'd0);
      w_blank[i] = lzb && (i != 0) && w_run;
    end
    w_bcd = (w_state != S_SCAN || w_blank[w_idx]) ? 4'hF : w_active[w_idx];
  end
  // scan state, active digits and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_OFF;
      r_idx         <= '0;
      r_cnt         <= '0;
      r_active      <= '1;
      r_pending     <= 1'b0;
      r_digit_en    <= '0;
      r_bcd         <= 4'hF;
      r_commit_done <= 1'b0;
      r_frame_tick  <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_idx         <= w_idx;
      r_cnt         <= w_cnt;
      r_active      <= w_active;
      r_pending     <= !w_apply && (r_pending || commit_req);
      r_digit_en    <= (w_state == S_SCAN) ? NUM_DIGITS'(1) << w_idx : '0;
      r_bcd         <= w_bcd;
      r_commit_done <= w_apply;
      r_frame_tick  <= w_frame_end;
    end
  end
  // shadow buffer writes; out-of-range addresses are dropped
  always_ff @(posedge clk) begin
    if (rst) r_shadow <= '1;
    else if (wr_en && 32'(wr_addr) < NUM_DIGITS) r_shadow[wr_addr] <= wr_data;
  end
  assign commit_done = r_commit_done;
  assign frame_tick  = r_frame_tick;
  assign bcd_out     = r_bcd;
  assign digit_en    = r_digit_en;
endmodule
